// File: rtl/udp_pkt_pkg.sv
// rtl/udp_pkt_pkg.sv - shared states, constants and field positions for the UDP packet dispatcher
package udp_pkt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SYNC,
        S_CHK_SYNC,
        S_RD_HDR,
        S_DEC_HDR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [31:0] DEF_SYNC_WORD = 32'h3A87C5D7;
    localparam int          DEF_NUM_CH    = 5;
    localparam logic [39:0] DEF_CH_CODES  = {8'h0B, 8'h0A, 8'h04, 8'h02, 8'h01};

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 24;
    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 0;

    function automatic logic [31:0] swap_hw(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

endpackage

// File: rtl/udp_pkt_dispatch_if.sv
// rtl/udp_pkt_dispatch_if.sv - receive-RAM read port and payload stream bundle
interface udp_pkt_dispatch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 5
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic [NUM_CH-1:0] ch_en;
    logic              pkt_done;

    modport master (output ram_addr, input ram_data, output data_out, output data_vld,
                    output ch_en, output pkt_done);
    modport slave  (input ram_addr, output ram_data, input data_out, input data_vld,
                    input ch_en, input pkt_done);
endinterface

// File: rtl/udp_toggle_sync.sv
// rtl/udp_toggle_sync.sv - pingpong synchroniser, edge detect and pending/overrun flag
module udp_toggle_sync (
    input  logic clk,
    input  logic nRST,
    input  logic i_toggle,
    input  logic i_clr,
    output logic o_pending,
    output logic o_overrun
);
    logic r_sync1, r_sync2, r_edge, r_pending, r_overrun;
    logic w_toggle;

    assign w_toggle  = r_sync2 ^ r_edge;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

    // A toggle in the same cycle the FSM consumes pending re-arms it without an overrun
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_edge    <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sync1   <= i_toggle;
            r_sync2   <= r_sync1;
            r_edge    <= r_sync2;
            r_pending <= w_toggle | (r_pending & ~i_clr);
            r_overrun <= w_toggle & r_pending & ~i_clr;
        end
    end
endmodule

// File: rtl/udp_pkt_dispatch.sv
// rtl/udp_pkt_dispatch.sv - reads a completed RAM bank, checks sync/type/length, streams payload to a channel
// Optional checksum word after the payload: PKT_CHKSUM_EN
module udp_pkt_dispatch
    import udp_pkt_pkg::*;
#(
    parameter int                  DATA_W    = 32,
    parameter int                  ADDR_W    = 10,
    parameter int                  HDR_ADDR  = 11,
    parameter logic [31:0]         SYNC_WORD = DEF_SYNC_WORD,
    parameter int                  NUM_CH    = DEF_NUM_CH,
    parameter logic [8*NUM_CH-1:0] CH_CODES  = DEF_CH_CODES,
    parameter int                  MAX_LEN   = 256,
    parameter int                  RAM_LAT   = 2
)(
    input  logic               clk,
    input  logic               nRST,
    input  logic               pingpong,
    udp_pkt_dispatch_if.master bus,
    output logic               err_sync,
    output logic               err_type,
    output logic               err_overrun,
`ifdef PKT_CHKSUM_EN
    output logic               err_chk,
`endif
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        drop_cnt
);
    localparam int BW = ADDR_W - 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [15:0]   LEN_CLAMP = 16'(MAX_LEN);
    localparam logic [BW-1:0] A_SYNC    = BW'(HDR_ADDR);
    localparam logic [BW-1:0] A_HDR     = BW'(HDR_ADDR + 1);
    localparam logic [BW-1:0] A_PAY     = BW'(HDR_ADDR + 2);

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [WW-1:0]       r_wait, w_wait;
    logic [16:0]         r_cnt, w_cnt;
    logic [IW-1:0]       r_idx, w_idx, w_hit_idx;
    logic [15:0]         w_len_raw, w_len;
    logic [RAM_LAT-1:0]  r_vpipe;
    logic                w_hit, w_take, w_pending, w_overrun, w_issue, w_start;
    logic                w_err_sync, w_err_type, w_done, w_pipe_busy, w_vin;
    logic                r_data_vld, r_pkt_done, r_err_sync, r_err_type;
    logic [DATA_W-1:0]   r_data_out;
    logic [15:0]         r_pkt_cnt, r_drop_cnt;

    udp_toggle_sync u_sync (
        .clk       (clk),
        .nRST      (nRST),
        .i_toggle  (pingpong),
        .i_clr     (w_take),
        .o_pending (w_pending),
        .o_overrun (w_overrun)
    );

    // Lowest matching index wins when a code is duplicated
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ram_data[TYPE_MSB:TYPE_LSB] == CH_CODES[8*i +: 8]) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
        end
    end

    assign w_len_raw = bus.ram_data[LEN_MSB:LEN_LSB];
    assign w_len     = (w_len_raw > LEN_CLAMP) ? LEN_CLAMP : w_len_raw;

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wait     = r_wait;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_take     = 1'b0;
        w_issue    = 1'b0;
        w_start    = 1'b0;
        w_err_sync = 1'b0;
        w_err_type = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: if (w_pending) begin
                w_take  = 1'b1;
                w_addr  = {r_addr[BW], A_SYNC};
                w_wait  = '0;
                w_state = S_RD_SYNC;
            end
            S_RD_SYNC, S_RD_HDR: begin
                if (r_wait == WW'(RAM_LAT - 1)) begin
                    w_wait  = '0;
                    w_state = (r_state == S_RD_SYNC) ? S_CHK_SYNC : S_DEC_HDR;
                end else begin
                    w_wait = r_wait + WW'(1);
                end
            end
            S_CHK_SYNC: begin
                if (bus.ram_data == SYNC_WORD) begin
                    w_addr  = {r_addr[BW], A_HDR};
                    w_state = S_RD_HDR;
                end else begin
                    w_err_sync = 1'b1;
                    w_addr     = {~r_addr[BW], r_addr[BW-1:0]};
                    w_state    = S_IDLE;
                end
            end
            S_DEC_HDR: begin
                if (!w_hit) begin
                    w_err_type = 1'b1;
                    w_addr     = {~r_addr[BW], r_addr[BW-1:0]};
                    w_state    = S_IDLE;
                end else if (w_len == 16'd0) begin
                    w_done  = 1'b1;
                    w_addr  = {~r_addr[BW], r_addr[BW-1:0]};
                    w_state = S_IDLE;
                end else begin
                    w_idx   = w_hit_idx;
                    w_addr  = {r_addr[BW], A_PAY};
                    w_start = 1'b1;
`ifdef PKT_CHKSUM_EN
                    w_cnt   = {1'b0, w_len} + 17'd1;
`else
                    w_cnt   = {1'b0, w_len};
`endif
                    w_state = S_STREAM;
                end
            end
            S_STREAM: begin
                w_issue = 1'b1;
                w_addr  = {r_addr[BW], r_addr[BW-1:0] + BW'(1)};
                w_cnt   = r_cnt - 17'd1;
                if (r_cnt == 17'd1)
                    w_state = S_DRAIN;
            end
            S_DRAIN: if (!w_pipe_busy) w_state = S_DONE;
            S_DONE: begin
                w_done  = 1'b1;
                w_addr  = {~r_addr[BW], r_addr[BW-1:0]};
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

`ifdef PKT_CHKSUM_EN
    // The final read of a packet is the checksum word and never reaches data_vld
    logic [RAM_LAT-1:0] r_cpipe;
    logic [DATA_W-1:0]  r_sum, r_chk_word;
    logic               r_err_chk, w_last_issue;

    assign w_last_issue = w_issue && (r_cnt == 17'd1);
    assign w_vin        = w_issue & ~w_last_issue;
    assign w_pipe_busy  = (|r_vpipe) | (|r_cpipe);
    assign err_chk      = r_err_chk;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_cpipe    <= '0;
            r_sum      <= '0;
            r_chk_word <= '0;
            r_err_chk  <= 1'b0;
        end else begin
            r_cpipe   <= (r_cpipe << 1) | RAM_LAT'(w_last_issue);
            r_err_chk <= w_done && (r_state == S_DONE) && (r_sum != r_chk_word);
            if (w_start)
                r_sum <= '0;
            else if (r_vpipe[RAM_LAT-1])
                r_sum <= r_sum + bus.ram_data;
            if (r_cpipe[RAM_LAT-1])
                r_chk_word <= bus.ram_data;
        end
    end
`else
    assign w_vin       = w_issue;
    assign w_pipe_busy = |r_vpipe;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wait     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_vpipe    <= '0;
            r_data_vld <= 1'b0;
            r_data_out <= '0;
            r_pkt_done <= 1'b0;
            r_err_sync <= 1'b0;
            r_err_type <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_wait     <= w_wait;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_vpipe    <= (r_vpipe << 1) | RAM_LAT'(w_vin);
            r_data_vld <= r_vpipe[RAM_LAT-1];
            r_data_out <= r_vpipe[RAM_LAT-1] ? swap_hw(bus.ram_data) : '0;
            r_pkt_done <= w_done;
            r_err_sync <= w_err_sync;
            r_err_type <= w_err_type;
            r_pkt_cnt  <= r_pkt_cnt + 16'(w_done);
            r_drop_cnt <= r_drop_cnt + 16'(w_overrun) + 16'(w_err_sync | w_err_type);
        end
    end

    assign bus.ram_addr = r_addr;
    assign bus.data_out = r_data_out;
    assign bus.data_vld = r_data_vld;
    assign bus.ch_en    = r_data_vld ? (NUM_CH'(1) << r_idx) : '0;
    assign bus.pkt_done = r_pkt_done;
    assign err_sync     = r_err_sync;
    assign err_type     = r_err_type;
    assign err_overrun  = w_overrun;
    assign pkt_cnt      = r_pkt_cnt;
    assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_udp_pkt_dispatch.sv
// tb/tb_udp_pkt_dispatch.sv - directed self-checking bench for udp_pkt_dispatch
module tb_udp_pkt_dispatch;
    localparam logic [31:0] SYNC = 32'h3A87C5D7;
    localparam int          HDR  = 11;

    logic        clk, nRST, pingpong;
    logic        err_sync, err_type, err_overrun;
    logic [15:0] pkt_cnt, drop_cnt;
`ifdef PKT_CHKSUM_EN
    logic        err_chk;
`endif

    udp_pkt_dispatch_if #(.DATA_W(32), .ADDR_W(10), .NUM_CH(5)) bus ();

    udp_pkt_dispatch dut (
        .clk         (clk),
        .nRST        (nRST),
        .pingpong    (pingpong),
        .bus         (bus),
        .err_sync    (err_sync),
        .err_type    (err_type),
        .err_overrun (err_overrun),
`ifdef PKT_CHKSUM_EN
        .err_chk     (err_chk),
`endif
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle registered RAM
    logic [31:0] mem [0:1023];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        rd_p0 <= mem[bus.ram_addr];
        rd_p1 <= rd_p0;
    end
    assign bus.ram_data = rd_p1;

    int n_checks = 0;
    int n_errors = 0;
    int done_n = 0, sync_n = 0, type_n = 0, ovr_n = 0, vld_n = 0, chen_idle_bad = 0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.data_vld) begin
            got_q.push_back({bus.ch_en, bus.data_out});
            vld_n++;
        end else if (bus.ch_en != 5'b0) begin
            chen_idle_bad++;
        end
        if (bus.pkt_done) done_n++;
        if (err_sync)     sync_n++;
        if (err_type)     type_n++;
        if (err_overrun)  ovr_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_pkt(input logic bank, input logic [31:0] sw, input logic [7:0] typ,
                           input logic [15:0] len, input int nwords, input logic [4:0] ch,
                           input logic [31:0] base, input logic [31:0] step);
        logic [31:0] w;
        mem[{bank, 9'(HDR)}]     = sw;
        mem[{bank, 9'(HDR + 1)}] = {typ, 8'h00, len};
        for (int i = 0; i < nwords; i++) begin
            w = base + step * i;
            mem[{bank, 9'(HDR + 2 + i)}] = w;
            exp_q.push_back({ch, w[15:0], w[31:16]});
        end
    endtask

    task automatic toggle();
        @(negedge clk);
        pingpong = ~pingpong;
    endtask

    task automatic wait_events(input int target, input int budget, input string tag);
        int c = 0;
        while ((done_n + sync_n + type_n) < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'((done_n + sync_n + type_n) >= target), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vld(input int budget, input string tag);
        int c = 0;
        int v0 = vld_n;
        while (vld_n == v0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(vld_n != v0), 32'd1);
    endtask

    task automatic compare_q(input string tag);
        int bad = 0;
        check({tag, "_words"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_data"}, 32'(bad), 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    int ev, s0, t0, o0, v0;

    initial begin
        nRST = 1'b0;
        pingpong = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_vld", 32'(bus.data_vld), 32'd0);
        check("rst_chen", 32'(bus.ch_en), 32'd0);
        check("rst_done", 32'(bus.pkt_done), 32'd0);
        check("rst_cnts", {pkt_cnt, drop_cnt}, 32'd0);
        nRST = 1'b1;

        // 1: good packet, type 0x02 -> channel 1
        put_pkt(1'b0, SYNC, 8'h02, 16'd4, 4, 5'b00010, 32'h11112222, 32'h22222222);
        ev = done_n + sync_n + type_n;
        toggle();
        wait_events(ev + 1, 100, "t1_timeout");
        compare_q("t1");
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("t1_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t1_bank", 32'(bus.ram_addr[9]), 32'd1);

        // 2: bad sync word on bank 1
        put_pkt(1'b1, 32'hDEADBEEF, 8'h02, 16'd4, 0, 5'b00010, 32'h0, 32'h0);
        ev = done_n + sync_n + type_n;
        s0 = sync_n; v0 = vld_n;
        toggle();
        wait_events(ev + 1, 100, "t2_timeout");
        check("t2_err_sync", 32'(sync_n - s0), 32'd1);
        check("t2_no_vld", 32'(vld_n - v0), 32'd0);
        check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t2_bank", 32'(bus.ram_addr[9]), 32'd0);

        // 3: unknown type, then known type with zero length
        put_pkt(1'b0, SYNC, 8'h07, 16'd4, 0, 5'b0, 32'h0, 32'h0);
        ev = done_n + sync_n + type_n;
        t0 = type_n;
        toggle();
        wait_events(ev + 1, 100, "t3a_timeout");
        check("t3_err_type", 32'(type_n - t0), 32'd1);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        put_pkt(1'b1, SYNC, 8'h0B, 16'd0, 0, 5'b0, 32'h0, 32'h0);
        ev = done_n + sync_n + type_n;
        v0 = vld_n;
        toggle();
        wait_events(ev + 1, 100, "t3b_timeout");
        check("t3_len0_no_vld", 32'(vld_n - v0), 32'd0);
        check("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);
        check("t3_bank", 32'(bus.ram_addr[9]), 32'd0);

        // 4: length 0x400 clamps to 256 words
        put_pkt(1'b0, SYNC, 8'h01, 16'h0400, 256, 5'b00001, 32'h00010003, 32'h00010003);
        ev = done_n + sync_n + type_n;
        toggle();
        wait_events(ev + 1, 600, "t4_timeout");
        compare_q("t4");
        check("t4_pkt_cnt", 32'(pkt_cnt), 32'd3);
        check("t4_bank", 32'(bus.ram_addr[9]), 32'd1);

        // 5: queued bank during STREAM, plus an overrun toggle
        put_pkt(1'b1, SYNC, 8'h04, 16'd32, 32, 5'b00100, 32'hA0000001, 32'h00030005);
        put_pkt(1'b0, SYNC, 8'h0A, 16'd3, 3, 5'b01000, 32'hCAFE0000, 32'h01010101);
        ev = done_n + sync_n + type_n;
        o0 = ovr_n;
        toggle();
        wait_vld(100, "t5_stream_timeout");
        toggle();
        repeat (5) @(negedge clk);
        toggle();
        wait_events(ev + 2, 400, "t5_timeout");
        check("t5_overrun", 32'(ovr_n - o0), 32'd1);
        compare_q("t5");
        check("t5_pkt_cnt", 32'(pkt_cnt), 32'd5);
        check("t5_drop_cnt", 32'(drop_cnt), 32'd3);
        check("t5_bank", 32'(bus.ram_addr[9]), 32'd1);

        // 6: reset in the middle of a stream, then a normal packet
        put_pkt(1'b1, SYNC, 8'h02, 16'd64, 0, 5'b0, 32'h0, 32'h0);
        toggle();
        wait_vld(100, "t6_stream_timeout");
        repeat (3) @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        check("t6_rst_vld", 32'(bus.data_vld), 32'd0);
        check("t6_rst_chen", 32'(bus.ch_en), 32'd0);
        check("t6_rst_addr", 32'(bus.ram_addr), 32'd0);
        check("t6_rst_dout", bus.data_out, 32'd0);
        check("t6_rst_cnts", {pkt_cnt, drop_cnt}, 32'd0);
        pingpong = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        got_q.delete();
        exp_q.delete();
        put_pkt(1'b0, SYNC, 8'h0A, 16'd2, 2, 5'b01000, 32'h12345678, 32'h11111111);
        ev = done_n + sync_n + type_n;
        toggle();
        wait_events(ev + 1, 100, "t6_timeout");
        compare_q("t6");
        check("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t6_bank", 32'(bus.ram_addr[9]), 32'd1);
        check("chen_idle", 32'(chen_idle_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
